// File: rtl/lcd_spi_pkg.sv
// Shared definitions for the LCD SPI feeder: SPI master register map,
// status register bit positions, FIFO entry layout and feeder FSM states.
package lcd_spi_pkg;

  // SPI master register addresses
  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;
  localparam logic [2:0] ADDR_SSEL    = 3'd5;
  localparam logic [2:0] ADDR_EOP     = 3'd6;

  // status register bit indices
  localparam int TMT  = 5;  // shifter empty
  localparam int TRDY = 6;  // TX holding register free
  localparam int RRDY = 7;  // RX data available

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_POLL1,
    S_POLL2,
    S_WAIT,
    S_WR1,
    S_WR2,
    S_GUARD
  } state_e;

endpackage

// File: rtl/lcd_spi_fifo.sv
// Synchronous FIFO of 9-bit {dc, data} entries.
// Ports: push/pop requests, wdata in, rdata = head entry (valid when !empty),
// full/empty flags and current occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module lcd_spi_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [8:0]               wdata,
  output logic [8:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/lcd_spi_feeder.sv
// Streams {D/C, byte} entries into the SPI master TX data register and
// sequences the LCD D/C pin so it only changes while the SPI shifter is empty.
// Ports: clk/reset_n; in_valid/in_ready/in_dc/in_data upstream entry port;
// spi_select/write_n/read_n/mem_addr/spi_wdata/spi_rdata/spi_readyfordata
// SPI register port; lcd_dc pin; busy; byte_count (bytes written, wraps).
module lcd_spi_feeder
  import lcd_spi_pkg::*;
#(
  parameter int   FIFO_DEPTH = 4,
  parameter logic DC_INIT    = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_dc,
  input  logic [7:0]  in_data,
  output logic        spi_select,
  output logic        write_n,
  output logic        read_n,
  output logic [2:0]  mem_addr,
  output logic [15:0] spi_wdata,
  input  logic [15:0] spi_rdata,
  input  logic        spi_readyfordata,
  output logic        lcd_dc,
  output logic        busy,
  output logic [15:0] byte_count
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e        state_q, state_d;
  logic          spi_select_q, spi_select_d;
  logic          write_n_q, write_n_d;
  logic          read_n_q, read_n_d;
  logic [2:0]    mem_addr_q, mem_addr_d;
  logic [15:0]   spi_wdata_q, spi_wdata_d;
  logic          lcd_dc_q, lcd_dc_d;
  logic [15:0]   byte_count_q, byte_count_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [8:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  entry_t        head;

  // only TMT is consumed from the status word
  logic unused_rdata;
  assign unused_rdata = ^{spi_rdata[15:TMT+1], spi_rdata[TMT-1:0]};

  assign head      = entry_t'(fifo_rdata);
  assign fifo_pop  = (state_q == S_WR2);
  // a full FIFO still takes a push in the cycle that frees a slot
  assign in_ready  = ~fifo_full | fifo_pop;
  assign fifo_push = in_valid & in_ready;
  assign busy      = (fifo_count != '0) | (state_q != S_IDLE);

  lcd_spi_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   ({in_dc, in_data}),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    lcd_dc_d     = lcd_dc_q;
    byte_count_d = byte_count_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_CHK;
      S_CHK:   state_d = (head.dc == lcd_dc_q) ? S_WAIT : S_POLL1;
      S_POLL1: state_d = S_POLL2;
      S_POLL2: begin
        if (spi_rdata[TMT]) begin
          lcd_dc_d = head.dc;
          state_d  = S_WAIT;
        end else begin
          state_d  = S_POLL1;
        end
      end
      S_WAIT:  if (spi_readyfordata) state_d = S_WR1;
      S_WR1:   state_d = S_WR2;
      S_WR2: begin
        byte_count_d = byte_count_q + 16'd1;
        state_d      = S_GUARD;
      end
      // the pop has already happened here, so go straight to the next entry;
      // this keeps back-to-back writes on a 5-cycle cadence
      S_GUARD: state_d = fifo_empty ? S_IDLE : S_CHK;
      default: state_d = S_IDLE;
    endcase

    // bus outputs are registered from the next state so they line up with it
    spi_select_d = 1'b0;
    write_n_d    = 1'b1;
    read_n_d     = 1'b1;
    mem_addr_d   = 3'd0;
    spi_wdata_d  = 16'h0000;
    case (state_d)
      S_POLL1, S_POLL2: begin
        spi_select_d = 1'b1;
        read_n_d     = 1'b0;
        mem_addr_d   = ADDR_STATUS;
      end
      S_WR1, S_WR2: begin
        spi_select_d = 1'b1;
        write_n_d    = 1'b0;
        mem_addr_d   = ADDR_TXDATA;
        spi_wdata_d  = {8'h00, head.data};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      spi_select_q <= 1'b0;
      write_n_q    <= 1'b1;
      read_n_q     <= 1'b1;
      mem_addr_q   <= 3'd0;
      spi_wdata_q  <= 16'h0000;
      lcd_dc_q     <= DC_INIT;
      byte_count_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      spi_select_q <= spi_select_d;
      write_n_q    <= write_n_d;
      read_n_q     <= read_n_d;
      mem_addr_q   <= mem_addr_d;
      spi_wdata_q  <= spi_wdata_d;
      lcd_dc_q     <= lcd_dc_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign spi_select = spi_select_q;
  assign write_n    = write_n_q;
  assign read_n     = read_n_q;
  assign mem_addr   = mem_addr_q;
  assign spi_wdata  = spi_wdata_q;
  assign lcd_dc     = lcd_dc_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_lcd_spi_feeder.sv
module tb_lcd_spi_feeder;
  localparam int DEPTH = 4;

  logic        clk, reset_n;
  logic        in_valid, in_ready, in_dc;
  logic [7:0]  in_data;
  logic        spi_select, write_n, read_n;
  logic [2:0]  mem_addr;
  logic [15:0] spi_wdata, spi_rdata;
  logic        spi_readyfordata, lcd_dc, busy;
  logic [15:0] byte_count;

  lcd_spi_feeder #(.FIFO_DEPTH(DEPTH), .DC_INIT(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_dc(in_dc), .in_data(in_data),
    .spi_select(spi_select), .write_n(write_n), .read_n(read_n),
    .mem_addr(mem_addr), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
    .spi_readyfordata(spi_readyfordata), .lcd_dc(lcd_dc), .busy(busy),
    .byte_count(byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---- SPI slave model / bus monitor ----
  int          tmt_zeros = 0;   // status reads still to answer with TMT=0
  int          passes = 0, writes = 0;
  bit          wr_phase = 0, rd_phase = 0;
  logic [15:0] first_data;
  int          wr_starts[$];
  logic [15:0] act_q[$], exp_q[$];
  logic        act_dc_q[$];

  always @(negedge clk) begin
    if (!reset_n) begin
      wr_phase = 0;
      rd_phase = 0;
    end else begin
      if (!write_n) begin
        chk("wr_sel", spi_select, 1);
        chk("wr_addr", mem_addr, 1);
        chk("wr_no_rd", read_n, 1);
        if (!wr_phase) begin
          wr_starts.push_back(cyc);
          first_data = spi_wdata;
          wr_phase = 1;
        end else begin
          chk("wr_hold", spi_wdata, first_data);
          act_q.push_back(spi_wdata);
          act_dc_q.push_back(lcd_dc);
          writes++;
          wr_phase = 0;
        end
      end else if (wr_phase) begin
        chk("wr_two_cycles", write_n, 0);
        wr_phase = 0;
      end
      if (!read_n) begin
        chk("rd_sel", spi_select, 1);
        chk("rd_addr", mem_addr, 2);
        if (!rd_phase) begin
          rd_phase = 1;
          spi_rdata = (tmt_zeros == 0) ? 16'h0060 : 16'h0040;
        end else begin
          rd_phase = 0;
          passes++;
          if (tmt_zeros > 0) tmt_zeros--;
        end
      end
    end
  end

  int push_cyc;
  task automatic push(input logic dc, input logic [7:0] d);
    int k = 0;
    while (!in_ready && k < 200) begin @(negedge clk); k++; end
    if (!in_ready) chk("push_timeout", in_ready, 1);
    in_valid = 1'b1; in_dc = dc; in_data = d;
    exp_q.push_back({8'h00, d});
    @(negedge clk);
    push_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    while (busy && k < lim) begin @(negedge clk); k++; end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic clear();
    passes = 0; writes = 0;
    wr_starts.delete(); act_q.delete(); act_dc_q.delete(); exp_q.delete();
  endtask

  typedef struct {
    logic        dc;
    logic [7:0]  data;
    int          zeros;
    logic [15:0] exp_wdata;
    logic        exp_dc;
    int          exp_passes;
    int          exp_lat;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t vt[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sdat[100];
    logic       sdc[100];
    int         i, g, fullpop_n, wb;
    bit         acc, fp;

    vt[0] = '{1'b0, 8'h2A, 0, 16'h002A, 1'b0, 0, 3, 16'd1};
    vt[1] = '{1'b1, 8'h55, 2, 16'h0055, 1'b1, 3, 9, 16'd2};
    vt[2] = '{1'b1, 8'hA5, 0, 16'h00A5, 1'b1, 0, 3, 16'd3};
    vt[3] = '{1'b0, 8'h00, 0, 16'h0000, 1'b0, 1, 5, 16'd4};
    vt[4] = '{1'b0, 8'hFF, 5, 16'h00FF, 1'b0, 0, 3, 16'd5};
    vt[5] = '{1'b1, 8'h3C, 1, 16'h003C, 1'b1, 2, 7, 16'd6};

    // ---- reset with in_valid held high ----
    reset_n = 1'b0; in_valid = 1'b1; in_dc = 1'b1; in_data = 8'hAA;
    spi_readyfordata = 1'b1; spi_rdata = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_select", spi_select, 0);
    chk("rst_write_n", write_n, 1);
    chk("rst_read_n", read_n, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", spi_wdata, 0);
    chk("rst_lcd_dc", lcd_dc, 0);
    chk("rst_count", byte_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    reset_n = 1'b1; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_lcd_dc", lcd_dc, 0);
    chk("post_rst_in_ready", in_ready, 1);

    // ---- single-byte vectors ----
    for (int v = 0; v < 6; v++) begin
      clear();
      tmt_zeros = vt[v].zeros;
      push(vt[v].dc, vt[v].data);
      wait_idle(100);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_writes", v), writes, 1);
      chk($sformatf("v%0d_passes", v), passes, vt[v].exp_passes);
      chk($sformatf("v%0d_lcd_dc", v), lcd_dc, vt[v].exp_dc);
      chk($sformatf("v%0d_count", v), byte_count, vt[v].exp_cnt);
      chk($sformatf("v%0d_busy", v), busy, 0);
      if (act_q.size() > 0) begin
        chk($sformatf("v%0d_wdata", v), act_q[0], vt[v].exp_wdata);
        chk($sformatf("v%0d_dc_at_write", v), act_dc_q[0], vt[v].exp_dc);
        chk($sformatf("v%0d_latency", v), wr_starts[0] - push_cyc, vt[v].exp_lat);
      end
    end

    // ---- backpressure: TRDY low with a full FIFO ----
    clear();
    tmt_zeros = 0;
    spi_readyfordata = 1'b0;
    push(1'b1, 8'h11); push(1'b1, 8'h22); push(1'b1, 8'h33); push(1'b1, 8'h44);
    repeat (20) @(negedge clk);
    chk("bp_no_writes", writes, 0);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_busy", busy, 1);
    spi_readyfordata = 1'b1;
    wait_idle(200);
    chk("bp_writes", writes, 4);
    chk("bp_count", byte_count, 10);
    if (wr_starts.size() == 4)
      for (int k = 1; k < 4; k++)
        chk($sformatf("bp_spacing%0d", k), wr_starts[k] - wr_starts[k-1], 5);
    if (act_q.size() == 4)
      for (int k = 0; k < 4; k++)
        chk($sformatf("bp_data%0d", k), act_q[k], exp_q[k]);

    // ---- 100-byte stream, FIFO kept full ----
    clear();
    for (int k = 0; k < 100; k++) begin
      sdat[k] = 8'($urandom);
      sdc[k]  = 1'($urandom_range(0, 1));
    end
    i = 0; g = 0; fullpop_n = 0;
    while (i < 100 && g < 3000) begin
      in_valid = 1'b1; in_dc = sdc[i]; in_data = sdat[i];
      acc = in_ready;
      fp  = in_ready && dut.u_fifo.full;
      @(negedge clk);
      g++;
      if (acc) begin exp_q.push_back({8'h00, sdat[i]}); i++; end
      if (fp) begin
        fullpop_n++;
        chk("full_pushpop_count", 32'(dut.u_fifo.count_q), DEPTH);
      end
    end
    in_valid = 1'b0;
    chk("stream_pushed", i, 100);
    chk("full_pushpop_seen", fullpop_n > 0, 1);
    wait_idle(1000);
    chk("stream_writes", act_q.size(), 100);
    chk("stream_count", byte_count, 110);
    if (act_q.size() == 100)
      for (int k = 0; k < 100; k++)
        chk($sformatf("stream_byte%0d", k), act_q[k], exp_q[k]);

    // ---- reset in the middle of WR1 ----
    clear();
    push(lcd_dc, 8'h77); push(lcd_dc, 8'h78); push(lcd_dc, 8'h79);
    g = 0;
    while (write_n && g < 100) begin @(negedge clk); g++; end
    chk("mid_found_wr1", write_n, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_write_n", write_n, 1);
    chk("mid_select", spi_select, 0);
    chk("mid_read_n", read_n, 1);
    chk("mid_in_ready", in_ready, 1);
    chk("mid_busy", busy, 0);
    chk("mid_count", byte_count, 0);
    chk("mid_lcd_dc", lcd_dc, 0);
    @(negedge clk);
    #3 reset_n = 1'b1;
    wb = writes;
    repeat (12) @(negedge clk);
    chk("mid_no_partial", writes, wb);
    chk("mid_idle", busy, 0);

    // ---- byte_count wrap ----
    clear();
    force dut.byte_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.byte_count_q;
    @(negedge clk);
    chk("wrap_preset", byte_count, 16'hFFFF);
    push(1'b0, 8'h5A);
    wait_idle(100);
    chk("wrap_count", byte_count, 16'h0000);
    chk("wrap_writes", writes, 1);
    if (act_q.size() > 0) chk("wrap_data", act_q[0], 16'h005A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
